// File: rtl/mem_burst_master.sv
// Burst front-end: splits a burst command into single-word memory accesses,
// one outstanding at a time. Define MEM_BURST_WRAP_EN for window-wrapping addresses.
module mem_burst_master #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [31:0]      cmd_addr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             cmd_write_i,
  input  logic [3:0]       cmd_bsel_i,
  input  logic             wdat_valid_i,
  output logic             wdat_ready_o,
  input  logic [31:0]      wdat_data_i,
  output logic             rdat_valid_o,
  input  logic             rdat_ready_i,
  output logic [31:0]      rdat_data_o,
  output logic             rdat_last_o,
  output logic             done_o,
  output logic [31:0]      mem_rd_addr_o,
  output logic [31:0]      mem_wr_addr_o,
  output logic             mem_rd_en_o,
  output logic             mem_wr_en_o,
  output logic [31:0]      mem_wr_data_o,
  output logic [3:0]       mem_wr_bsel_o,
  input  logic [31:0]      mem_rd_data_i,
  input  logic             mem_rd_valid_i,
  input  logic             mem_wr_ack_i
);

  typedef enum logic [2:0] {StIdle, StWdata, StIssue, StWait, StOut, StDone} state_e;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               write_q, write_d;
  logic [3:0]         bsel_q, bsel_d;
  logic [31:0]        wbuf_q, wbuf_d;
  logic [31:0]        rdat_data_q, rdat_data_d;
  logic               rdat_valid_q, rdat_valid_d;
  logic               rdat_last_q, rdat_last_d;
  logic [31:0]        addr_inc;
  logic               last_beat;

`ifdef MEM_BURST_WRAP_EN
  // Only the low LEN_W bits advance, keeping the burst inside its aligned window.
  assign addr_inc = {addr_q[31:LEN_W], addr_q[LEN_W-1:0] + LEN_W'(1)};
`else
  assign addr_inc = addr_q + 32'd1;
`endif

  assign last_beat = (cnt_q == len_q);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      bsel_q       <= '0;
      wbuf_q       <= '0;
      rdat_data_q  <= '0;
      rdat_valid_q <= 1'b0;
      rdat_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      bsel_q       <= bsel_d;
      wbuf_q       <= wbuf_d;
      rdat_data_q  <= rdat_data_d;
      rdat_valid_q <= rdat_valid_d;
      rdat_last_q  <= rdat_last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    bsel_d       = bsel_q;
    wbuf_d       = wbuf_q;
    rdat_data_d  = rdat_data_q;
    rdat_valid_d = rdat_valid_q;
    rdat_last_d  = rdat_last_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          len_d   = cmd_len_i;
          write_d = cmd_write_i;
          bsel_d  = cmd_bsel_i;
          cnt_d   = '0;
          state_d = cmd_write_i ? StWdata : StIssue;
        end
      end
      StWdata: begin
        if (wdat_valid_i) begin
          wbuf_d  = wdat_data_i;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        // Responses of the wrong type are dropped; only the matching one advances.
        if (!write_q && mem_rd_valid_i) begin
          rdat_data_d  = mem_rd_data_i;
          rdat_valid_d = 1'b1;
          rdat_last_d  = last_beat;
          state_d      = StOut;
        end else if (write_q && mem_wr_ack_i) begin
          if (last_beat) begin
            state_d = StDone;
          end else begin
            addr_d  = addr_inc;
            cnt_d   = cnt_q + LEN_W'(1);
            state_d = StWdata;
          end
        end
      end
      StOut: begin
        if (rdat_ready_i) begin
          rdat_valid_d = 1'b0;
          if (last_beat) begin
            state_d = StDone;
          end else begin
            addr_d  = addr_inc;
            cnt_d   = cnt_q + LEN_W'(1);
            state_d = StIssue;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready_o   = (state_q == StIdle);
    wdat_ready_o  = (state_q == StWdata);
    mem_rd_en_o   = (state_q == StIssue) && !write_q;
    mem_wr_en_o   = (state_q == StIssue) && write_q;
    done_o        = (state_q == StDone);
    mem_rd_addr_o = addr_q;
    mem_wr_addr_o = addr_q;
    mem_wr_data_o = wbuf_q;
    mem_wr_bsel_o = bsel_q;
    rdat_valid_o  = rdat_valid_q;
    rdat_data_o   = rdat_data_q;
    rdat_last_o   = rdat_last_q;
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a one-cycle-latency memory model
// that can hold read responses and inject stray write acks.
module tb_mem_burst_master;
  localparam int unsigned LEN_W = 4;

  logic             clk = 1'b0;
  logic             arst;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [31:0]      cmd_addr_i;
  logic [LEN_W-1:0] cmd_len_i;
  logic             cmd_write_i;
  logic [3:0]       cmd_bsel_i;
  logic             wdat_valid_i = 1'b0;
  logic             wdat_ready_o;
  logic [31:0]      wdat_data_i = 32'h0;
  logic             rdat_valid_o;
  logic             rdat_ready_i;
  logic [31:0]      rdat_data_o;
  logic             rdat_last_o;
  logic             done_o;
  logic [31:0]      mem_rd_addr_o;
  logic [31:0]      mem_wr_addr_o;
  logic             mem_rd_en_o;
  logic             mem_wr_en_o;
  logic [31:0]      mem_wr_data_o;
  logic [3:0]       mem_wr_bsel_o;
  logic [31:0]      mem_rd_data_i;
  logic             mem_rd_valid_i;
  logic             mem_wr_ack_i;

  mem_burst_master #(.LEN_W(LEN_W)) dut (
    .clk           (clk),
    .arst          (arst),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_len_i     (cmd_len_i),
    .cmd_write_i   (cmd_write_i),
    .cmd_bsel_i    (cmd_bsel_i),
    .wdat_valid_i  (wdat_valid_i),
    .wdat_ready_o  (wdat_ready_o),
    .wdat_data_i   (wdat_data_i),
    .rdat_valid_o  (rdat_valid_o),
    .rdat_ready_i  (rdat_ready_i),
    .rdat_data_o   (rdat_data_o),
    .rdat_last_o   (rdat_last_o),
    .done_o        (done_o),
    .mem_rd_addr_o (mem_rd_addr_o),
    .mem_wr_addr_o (mem_wr_addr_o),
    .mem_rd_en_o   (mem_rd_en_o),
    .mem_wr_en_o   (mem_wr_en_o),
    .mem_wr_data_o (mem_wr_data_o),
    .mem_wr_bsel_o (mem_wr_bsel_o),
    .mem_rd_data_i (mem_rd_data_i),
    .mem_rd_valid_i(mem_rd_valid_i),
    .mem_wr_ack_i  (mem_wr_ack_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory model, indexed by the low address byte.
  logic [31:0] mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = 8'h0;
  logic [31:0] pl_data = 32'h0;
  logic        rd_hold = 1'b0;
  logic        inj_ack = 1'b0;
  logic        rd_pend;
  logic [7:0]  rd_pend_addr;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] bsel);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) if (bsel[b]) res[8*b +: 8] = data[8*b +: 8];
    return res;
  endfunction

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      mem_rd_valid_i <= 1'b0;
      mem_wr_ack_i   <= 1'b0;
      mem_rd_data_i  <= 32'h0;
      rd_pend        <= 1'b0;
      rd_pend_addr   <= 8'h0;
    end else begin
      mem_rd_valid_i <= 1'b0;
      mem_wr_ack_i   <= inj_ack;
      if (pl_en) mem[pl_addr] <= pl_data;
      if (mem_rd_en_o) begin
        if (rd_hold) begin
          rd_pend      <= 1'b1;
          rd_pend_addr <= mem_rd_addr_o[7:0];
        end else begin
          mem_rd_valid_i <= 1'b1;
          mem_rd_data_i  <= mem[mem_rd_addr_o[7:0]];
        end
      end else if (rd_pend && !rd_hold) begin
        mem_rd_valid_i <= 1'b1;
        mem_rd_data_i  <= mem[rd_pend_addr];
        rd_pend        <= 1'b0;
      end
      if (mem_wr_en_o) begin
        mem[mem_wr_addr_o[7:0]] <= merge(mem[mem_wr_addr_o[7:0]], mem_wr_data_o, mem_wr_bsel_o);
        mem_wr_ack_i <= 1'b1;
      end
    end
  end

  // Write-data source: presents queued words, advancing on handshake.
  logic [31:0] wq [$];
  always @(posedge clk) begin
    if (wdat_valid_i && wdat_ready_o) void'(wq.pop_front());
    #1;
    wdat_valid_i <= (wq.size() != 0);
    wdat_data_i  <= (wq.size() != 0) ? wq[0] : 32'h0;
  end

  // Monitor: logs strobes, beats and done pulses with cycle stamps.
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          acc_cyc = 0;
  int          strobe_cyc [$];
  logic [31:0] rd_addr_q [$];
  logic [31:0] wr_addr_q [$];
  logic [31:0] beat_data [$];
  logic        beat_last [$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid_i && cmd_ready_o) acc_cyc <= cyc;
    if (mem_rd_en_o) begin
      rd_addr_q.push_back(mem_rd_addr_o);
      strobe_cyc.push_back(cyc);
    end
    if (mem_wr_en_o) begin
      wr_addr_q.push_back(mem_wr_addr_o);
      strobe_cyc.push_back(cyc);
    end
    if (rdat_valid_o && rdat_ready_i) begin
      beat_data.push_back(rdat_data_o);
      beat_last.push_back(rdat_last_o);
    end
    if (done_o) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [LEN_W-1:0] len, input logic wr,
                          input logic [3:0] bsel);
    rd_addr_q.delete(); wr_addr_q.delete(); strobe_cyc.delete();
    beat_data.delete(); beat_last.delete();
    cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_len_i = len; cmd_write_i = wr; cmd_bsel_i = bsel;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int start;
    int i;
    start = done_cnt;
    i = 0;
    while (done_cnt == start && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    check_eq({tag, " done"}, 32'(done_cnt - start), 32'd1);
  endtask

  task automatic wait_rd_strobes(input int n, input int budget, input string tag);
    int i;
    i = 0;
    while (rd_addr_q.size() < n && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    check_eq({tag, " strobes"}, 32'(rd_addr_q.size()), 32'(n));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] exp_addr [4];
  logic [31:0] wbase;
  int          d0;

  initial begin
    arst = 1'b1;
    cmd_valid_i = 1'b0; cmd_addr_i = 32'h0; cmd_len_i = '0; cmd_write_i = 1'b0;
    cmd_bsel_i = 4'h0; rdat_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst cmd_ready", 32'(cmd_ready_o), 32'd1);
    check_eq("rst wdat_ready", 32'(wdat_ready_o), 32'd0);
    check_eq("rst rdat_valid", 32'(rdat_valid_o), 32'd0);
    check_eq("rst rdat_data", rdat_data_o, 32'h0);
    check_eq("rst done", 32'(done_o), 32'd0);
    check_eq("rst strobes", 32'({mem_rd_en_o, mem_wr_en_o}), 32'd0);
    check_eq("rst addr", mem_rd_addr_o, 32'h0);
    check_eq("rst wr_data", mem_wr_data_o, 32'h0);
    arst = 1'b0;
    @(posedge clk); #1;

    // Read burst, 4 beats, ready held high.
    for (int i = 0; i < 4; i++) preload(8'(8'h10 + i), 32'(32'hA0 + i));
    rdat_ready_i = 1'b1;
    send_cmd(32'h10, 4'd3, 1'b0, 4'h0);
    wait_done(60, "rd4");
    check_eq("rd4 beats", 32'(beat_data.size()), 32'd4);
    for (int i = 0; i < 4 && i < beat_data.size(); i++) begin
      check_eq($sformatf("rd4 data%0d", i), beat_data[i], 32'(32'hA0 + i));
      check_eq($sformatf("rd4 last%0d", i), 32'(beat_last[i]), 32'(i == 3));
      check_eq($sformatf("rd4 addr%0d", i), rd_addr_q[i], 32'(32'h10 + i));
    end
    if (strobe_cyc.size() > 0) begin
      check_eq("rd4 issue->done", 32'(done_cyc - strobe_cyc[0]), 32'd12);
      check_eq("rd4 accept->strobe", 32'(strobe_cyc[0] - acc_cyc), 32'd1);
    end
    @(posedge clk); #1;
    check_eq("rd4 cmd_ready after done", 32'(cmd_ready_o), 32'd1);

    // Write burst, 2 beats, partial byte selects.
    preload(8'h20, 32'hFFFF_FFFF);
    preload(8'h21, 32'hFFFF_FFFF);
    wq.push_back(32'h1122_3344);
    wq.push_back(32'h5566_7788);
    send_cmd(32'h20, 4'd1, 1'b1, 4'h3);
    wait_done(60, "wr2");
    check_eq("wr2 mem0", mem[8'h20], 32'hFFFF_3344);
    check_eq("wr2 mem1", mem[8'h21], 32'hFFFF_7788);
    check_eq("wr2 wr_en count", 32'(wr_addr_q.size()), 32'd2);
    check_eq("wr2 rd_en count", 32'(rd_addr_q.size()), 32'd0);
    if (wr_addr_q.size() == 2) check_eq("wr2 addr1", wr_addr_q[1], 32'h21);
    if (strobe_cyc.size() > 0) check_eq("wr2 accept->strobe", 32'(strobe_cyc[0] - acc_cyc), 32'd2);

    // Read with consumer stalled on beat 0.
    preload(8'h30, 32'hB0);
    preload(8'h31, 32'hB1);
    rdat_ready_i = 1'b0;
    send_cmd(32'h30, 4'd1, 1'b0, 4'h0);
    d0 = 0;
    while (!rdat_valid_o && d0 < 20) begin
      @(posedge clk); #1;
      d0++;
    end
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("stall data c%0d", k), rdat_data_o, 32'hB0);
      check_eq($sformatf("stall valid c%0d", k), 32'(rdat_valid_o), 32'd1);
      @(posedge clk); #1;
    end
    check_eq("stall rd_en count", 32'(rd_addr_q.size()), 32'd1);
    rdat_ready_i = 1'b1;
    wait_done(40, "stall");
    check_eq("stall beats", 32'(beat_data.size()), 32'd2);
    if (beat_data.size() == 2) check_eq("stall beat1", beat_data[1], 32'hB1);

    // Address stepping at the top of the address space / inside the wrap window.
`ifdef MEM_BURST_WRAP_EN
    wbase = 32'h1E;
    exp_addr[0] = 32'h1E; exp_addr[1] = 32'h1F; exp_addr[2] = 32'h10; exp_addr[3] = 32'h11;
`else
    wbase = 32'hFFFF_FFFE;
    exp_addr[0] = 32'hFFFF_FFFE; exp_addr[1] = 32'hFFFF_FFFF;
    exp_addr[2] = 32'h0;         exp_addr[3] = 32'h1;
`endif
    send_cmd(wbase, 4'd3, 1'b0, 4'h0);
    wait_done(60, "wrap");
    check_eq("wrap strobes", 32'(rd_addr_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < rd_addr_q.size(); i++)
      check_eq($sformatf("wrap addr%0d", i), rd_addr_q[i], exp_addr[i]);

    // Reset while waiting on beat 2 of an 8-beat read.
    send_cmd(32'h40, 4'd7, 1'b0, 4'h0);
    wait_rd_strobes(2, 30, "abort b1");
    rd_hold = 1'b1;
    wait_rd_strobes(3, 30, "abort b2");
    @(posedge clk); #1;
    d0 = done_cnt;
    arst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort cmd_ready", 32'(cmd_ready_o), 32'd1);
    check_eq("abort rdat_valid", 32'(rdat_valid_o), 32'd0);
    check_eq("abort addr", mem_rd_addr_o, 32'h0);
    check_eq("abort strobes", 32'({mem_rd_en_o, mem_wr_en_o}), 32'd0);
    arst = 1'b0;
    rd_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("abort no done", 32'(done_cnt - d0), 32'd0);
    send_cmd(32'h10, 4'd0, 1'b0, 4'h0);
    wait_done(30, "post-abort");
    if (beat_data.size() > 0) check_eq("post-abort data", beat_data[0], 32'hA0);

    // Stray write ack while a read is waiting.
    preload(8'h50, 32'hC5);
    rd_hold = 1'b1;
    send_cmd(32'h50, 4'd0, 1'b0, 4'h0);
    wait_rd_strobes(1, 20, "spur");
    d0 = done_cnt;
    inj_ack = 1'b1;
    @(posedge clk); #1;
    inj_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("spur rdat_valid", 32'(rdat_valid_o), 32'd0);
    check_eq("spur no done", 32'(done_cnt - d0), 32'd0);
    check_eq("spur rd_en count", 32'(rd_addr_q.size()), 32'd1);
    rd_hold = 1'b0;
    wait_done(30, "spur");
    check_eq("spur beats", 32'(beat_data.size()), 32'd1);
    if (beat_data.size() > 0) check_eq("spur data", beat_data[0], 32'hC5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
